// File: rtl/l2_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped L2 cache controller.
package l2_cache_pkg;

  localparam int N          = 32;
  localparam int ADDR_W     = 15;
  localparam int OFFSET_W   = 4;
  localparam int INDEX_W    = 7;
  localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
  localparam int BLOCK_SIZE = 1 << OFFSET_W;
  localparam int NUM_SETS   = 1 << INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_FILL,
    ST_STREAM,
    ST_WR_CAPTURE,
    ST_MEM_WRITE,
    ST_FLUSH
  } l2_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } l2_addr_t;

  function automatic l2_addr_t split_addr(input logic [ADDR_W-1:0] addr);
    l2_addr_t f;
    f.tag    = addr[ADDR_W-1 -: TAG_W];
    f.index  = addr[OFFSET_W +: INDEX_W];
    f.offset = addr[OFFSET_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/l2_cache_ctrl_if.sv
// L1-facing and backing-memory signals of the L2 controller.
// Handshakes: L1 read is a level held until the 16-word stream ends; L1 write is a
// one-cycle pulse with address/data valid the following cycle; memory holds mem_req
// (with stable mem_addr/mem_we/mem_wdata) until a cycle where mem_ack is sampled high.
interface l2_cache_ctrl_if
  import l2_cache_pkg::*;
  ();

  logic [ADDR_W-1:0] L2_word_address;
  logic [N-1:0]      L2_write_word;
  logic              L2_read_request;
  logic              L2_write_request;
  logic              flush_req;
  logic [N-1:0]      L2_read_word;
  logic              L2_busy;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [N-1:0]      mem_wdata;
  logic [N-1:0]      mem_rdata;
  logic              mem_ack;

  modport slave (
    input  L2_word_address, L2_write_word, L2_read_request, L2_write_request, flush_req,
    input  mem_rdata, mem_ack,
    output L2_read_word, L2_busy, flush,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output L2_word_address, L2_write_word, L2_read_request, L2_write_request, flush_req,
    output mem_rdata, mem_ack,
    input  L2_read_word, L2_busy, flush,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/l2_tag_data_array.sv
// Valid/tag/data storage for the L2: combinational read, one word write port,
// tag write that also sets valid, and single-cycle bulk invalidate.
module l2_tag_data_array
  import l2_cache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inval_all_i,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [N-1:0]        rd_data_o,
  input  logic                data_we_i,
  input  logic                tag_we_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [N-1:0]        wr_data_i,
  input  logic [TAG_W-1:0]    wr_tag_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [N-1:0]        data_q [NUM_SETS][BLOCK_SIZE];

  // Only valid bits are reset; stale tags/data are harmless behind a clear valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (inval_all_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
    if (data_we_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped, word-serial, write-through/no-allocate L2 controller behind the L1.
// Optional L2_STATS_EN adds saturating hit/miss/write counters as extra outputs.
module l2_cache_ctrl
  import l2_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  l2_cache_ctrl_if.slave    bus,
`ifdef L2_STATS_EN
  output logic [15:0]       L2_hit_count,
  output logic [15:0]       L2_miss_count,
  output logic [15:0]       L2_write_count,
`endif
  output l2_state_e         dbg_state_o
);

  l2_state_e           state_q, state_d;
  logic [OFFSET_W-1:0] wcnt_q, wcnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [N-1:0]        wr_data_q, wr_data_d;

  l2_addr_t            addr_f;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [N-1:0]        rd_data;
  logic                hit;
  logic                data_we, tag_we, inval_all;
  logic [OFFSET_W-1:0] wr_offset;
  logic [N-1:0]        wr_wdata;

  assign addr_f = split_addr(bus.L2_word_address);
  assign hit    = rd_valid && (rd_tag == addr_f.tag);

  l2_tag_data_array u_array (
    .clk         (clk),
    .reset       (reset),
    .inval_all_i (inval_all),
    .rd_index_i  (addr_f.index),
    .rd_offset_i (wcnt_q),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .data_we_i   (data_we),
    .tag_we_i    (tag_we),
    .wr_index_i  (addr_f.index),
    .wr_offset_i (wr_offset),
    .wr_data_i   (wr_wdata),
    .wr_tag_i    (addr_f.tag)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      flush_pend_q <= flush_pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wcnt_d           = wcnt_q;
    flush_pend_d     = flush_pend_q | bus.flush_req;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    bus.L2_busy      = 1'b0;
    bus.flush        = 1'b0;
    bus.L2_read_word = '0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    data_we          = 1'b0;
    tag_we           = 1'b0;
    inval_all        = 1'b0;
    wr_offset        = wcnt_q;
    wr_wdata         = bus.mem_rdata;

    case (state_q)
      ST_IDLE: begin
        // Busy tracks a read request immediately so L1 never samples a stale word.
        bus.L2_busy = bus.L2_read_request;
        if (flush_pend_q || bus.flush_req) begin
          flush_pend_d = 1'b0;
          state_d      = ST_FLUSH;
        end else if (bus.L2_write_request) begin
          state_d = ST_WR_CAPTURE;
        end else if (bus.L2_read_request) begin
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        bus.L2_busy = 1'b1;
        wcnt_d      = '0;
        state_d     = hit ? ST_STREAM : ST_MEM_FILL;
      end
      ST_MEM_FILL: begin
        bus.L2_busy  = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_f.tag, addr_f.index, wcnt_q};
        if (bus.mem_ack) begin
          data_we = 1'b1;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == '1) begin
            tag_we  = 1'b1;
            wcnt_d  = '0;
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        bus.L2_read_word = rd_data;
        wcnt_d           = wcnt_q + 1'b1;
        if (wcnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_CAPTURE: begin
        bus.L2_busy = 1'b1;
        wr_addr_d   = bus.L2_word_address;
        wr_data_d   = bus.L2_write_word;
        if (hit) begin
          data_we   = 1'b1;
          wr_offset = addr_f.offset;
          wr_wdata  = bus.L2_write_word;
        end
        state_d = ST_MEM_WRITE;
      end
      ST_MEM_WRITE: begin
        bus.L2_busy   = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wr_addr_q;
        bus.mem_wdata = wr_data_q;
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        bus.L2_busy = 1'b1;
        bus.flush   = 1'b1;
        inval_all   = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

`ifdef L2_STATS_EN
  logic        hit_inc, miss_inc, write_inc;
  logic [15:0] hit_cnt_q, miss_cnt_q, write_cnt_q;

  assign hit_inc   = (state_q == ST_LOOKUP) && hit;
  assign miss_inc  = (state_q == ST_LOOKUP) && !hit;
  assign write_inc = (state_q == ST_WR_CAPTURE);

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      write_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1))     hit_cnt_q   <= hit_cnt_q + 16'd1;
      if (miss_inc && (miss_cnt_q != '1))   miss_cnt_q  <= miss_cnt_q + 16'd1;
      if (write_inc && (write_cnt_q != '1)) write_cnt_q <= write_cnt_q + 16'd1;
    end
  end

  assign L2_hit_count   = hit_cnt_q;
  assign L2_miss_count  = miss_cnt_q;
  assign L2_write_count = write_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed bench for l2_cache_ctrl: refill miss/hit, write-through hit/miss,
// deferred and direct flush, and reset in the middle of a fill.
module tb_l2_cache_ctrl;
  import l2_cache_pkg::*;

  logic      clk;
  logic      reset;
  l2_state_e dbg_state;
  int        n_vec;
  int        n_miss;
  logic [31:0] exp_q[$];
  logic [31:0] bmem [0:32767];

  l2_cache_ctrl_if bus ();

  l2_cache_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: acks every cycle a request is seen, returns bench memory contents.
  always @(negedge clk) begin
    bus.mem_ack   = bus.mem_req;
    bus.mem_rdata = bmem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read of the block holding addr; flush_beat >= 0 pulses flush_req during that fill beat.
  task automatic do_read(input logic [14:0] addr, input bit exp_miss, input int flush_beat);
    logic [14:0] base;
    base = {addr[14:4], 4'h0};
    for (int i = 0; i < 16; i++) exp_q.push_back(bmem[base + 15'(i)]);
    bus.L2_word_address = addr;
    bus.L2_read_request = 1'b1;
    @(negedge clk);
    chk("rd_idle_busy", bus.L2_busy, 1);
    next_cycle();
    @(negedge clk);
    chk("rd_lookup_state", 32'(dbg_state), 32'(ST_LOOKUP));
    chk("rd_lookup_busy", bus.L2_busy, 1);
    chk("rd_lookup_noreq", bus.mem_req, 0);
    next_cycle();
    if (exp_miss) begin
      for (int b = 0; b < 16; b++) begin
        bus.flush_req = (b == flush_beat);
        @(negedge clk);
        chk("fill_req", bus.mem_req, 1);
        chk("fill_we", bus.mem_we, 0);
        chk("fill_addr", 32'(bus.mem_addr), 32'(base + 15'(b)));
        chk("fill_busy", bus.L2_busy, 1);
        next_cycle();
      end
      bus.flush_req = 1'b0;
    end
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      chk("stream_busy", bus.L2_busy, 0);
      chk("stream_noreq", bus.mem_req, 0);
      chk("stream_word", bus.L2_read_word, exp_q.pop_front());
      next_cycle();
    end
    bus.L2_read_request = 1'b0;
    if (flush_beat >= 0) begin
      @(negedge clk);
      chk("pend_idle_flush", bus.flush, 0);
      next_cycle();
      @(negedge clk);
      chk("pend_flush_pulse", bus.flush, 1);
      chk("pend_flush_busy", bus.L2_busy, 1);
      chk("pend_flush_state", 32'(dbg_state), 32'(ST_FLUSH));
      next_cycle();
    end
    @(negedge clk);
    chk("rd_done_busy", bus.L2_busy, 0);
    chk("rd_done_flush", bus.flush, 0);
    chk("rd_done_state", 32'(dbg_state), 32'(ST_IDLE));
    next_cycle();
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [31:0] data);
    bus.L2_write_request = 1'b1;
    @(negedge clk);
    chk("wr_idle_busy", bus.L2_busy, 0);
    next_cycle();
    bus.L2_write_request = 1'b0;
    bus.L2_word_address  = addr;
    bus.L2_write_word    = data;
    @(negedge clk);
    chk("wr_cap_state", 32'(dbg_state), 32'(ST_WR_CAPTURE));
    chk("wr_cap_busy", bus.L2_busy, 1);
    chk("wr_cap_noreq", bus.mem_req, 0);
    next_cycle();
    bus.L2_word_address = 15'h0;
    bus.L2_write_word   = 32'h0;
    @(negedge clk);
    chk("wr_mem_req", bus.mem_req, 1);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'(addr));
    chk("wr_mem_wdata", bus.mem_wdata, data);
    chk("wr_mem_busy", bus.L2_busy, 1);
    next_cycle();
    @(negedge clk);
    chk("wr_done_req", bus.mem_req, 0);
    chk("wr_done_busy", bus.L2_busy, 0);
    next_cycle();
    bmem[addr] = data;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_busy"}, bus.L2_busy, 0);
    chk({tag, "_flush"}, bus.flush, 0);
    chk({tag, "_req"}, bus.mem_req, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_rword"}, bus.L2_read_word, 0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int a = 0; a < 32768; a++) begin
      logic [14:0] aa;
      aa = 15'(a);
      bmem[a] = (aa[14:4] == 11'h123) ? (32'hA0 + 32'(aa[3:0])) : (32'h5A000000 | 32'(aa));
    end
    reset                = 1'b0;
    bus.L2_word_address  = '0;
    bus.L2_write_word    = '0;
    bus.L2_read_request  = 1'b0;
    bus.L2_write_request = 1'b0;
    bus.flush_req        = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk_idle_outputs("reset");
    next_cycle();
    reset = 1'b1;
    next_cycle();

    do_read(15'h1230, 1'b1, -1);          // cold miss: A0..AF
    do_read(15'h1234, 1'b0, -1);          // hit, no memory traffic
    do_write(15'h1235, 32'hDEADBEEF);     // write hit, through to memory
    do_read(15'h1230, 1'b0, -1);          // hit shows updated word 5
    do_write(15'h7FF0, 32'h11223344);     // write miss, no allocate
    do_read(15'h7FF0, 1'b1, -1);          // still a miss
    do_read(15'h0450, 1'b1, 3);           // flush during fill, serviced after stream
    do_read(15'h1230, 1'b1, -1);          // flushed: miss, memory has DEADBEEF at word 5

    // Reset in the middle of a fill at beat 8.
    bus.L2_word_address = 15'h0AB3;
    bus.L2_read_request = 1'b1;
    next_cycle();
    next_cycle();
    for (int b = 0; b < 8; b++) next_cycle();
    @(negedge clk);
    chk("rst_beat8_addr", 32'(bus.mem_addr), 32'h0AB8);
    next_cycle();
    reset               = 1'b0;
    bus.L2_read_request = 1'b0;
    next_cycle();
    @(negedge clk);
    chk_idle_outputs("midfill_reset");
    next_cycle();
    reset = 1'b1;
    next_cycle();
    do_read(15'h0AB3, 1'b1, -1);          // partial fill left the block invalid
    do_read(15'h0AB3, 1'b0, -1);

    // Direct flush from IDLE.
    bus.flush_req = 1'b1;
    @(negedge clk);
    chk("idle_flush_pre", bus.flush, 0);
    next_cycle();
    bus.flush_req = 1'b0;
    @(negedge clk);
    chk("idle_flush_pulse", bus.flush, 1);
    chk("idle_flush_busy", bus.L2_busy, 1);
    next_cycle();
    @(negedge clk);
    chk("idle_flush_post", bus.flush, 0);
    next_cycle();
    do_read(15'h0AB3, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
